sccb_init_sequencer: RTL and testbench



---
 rtl/sccb_init_sequencer.sv | 139 +++++++++++++
 tb/tb_sccb_init_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_init_sequencer.sv
// OV7670 register-init sequencer: walks a fixed ROM of SCCB writes and feeds them to the transceiver.
// Optional completion timeout enabled by defining SCCB_INIT_TIMEOUT_EN.
module sccb_init_sequencer #(
  parameter logic [7:0]  DEV_ID         = 8'h42,
  parameter int unsigned DELAY_CYCLES   = 100000,
  parameter int unsigned ROM_DEPTH      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_start,
  input  logic                         i_sccb_done,
  output logic                         o_sccb_start,
  output logic [23:0]                  o_sccb_word,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_error,
  output logic [$clog2(ROM_DEPTH)-1:0] o_index
);

  localparam int unsigned IW  = $clog2(ROM_DEPTH);
  localparam int unsigned DCW = $clog2(DELAY_CYCLES + 1);

  localparam logic [15:0]   END_MARK   = 16'hFFFF;
  localparam logic [15:0]   DELAY_MARK = 16'hFFF0;
  localparam logic [IW-1:0] LAST_IDX   = IW'(ROM_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_DELAY,
    S_FINISHED,
    S_ERROR
  } state_t;

  state_t         state;
  logic [IW-1:0]  index;
  logic [DCW-1:0] delay_cnt;
  logic [15:0]    rom_entry;

  always_comb begin
    rom_entry = END_MARK;
    case (int'(index))
      0:       rom_entry = 16'h1280;
      1:       rom_entry = DELAY_MARK;
      2:       rom_entry = 16'h1204;
      3:       rom_entry = 16'h40D0;
      4:       rom_entry = 16'h1101;
      5:       rom_entry = 16'h0C00;
      6:       rom_entry = 16'h3E00;
      default: rom_entry = END_MARK;
    endcase
  end

  assign o_index = index;

`ifdef SCCB_INIT_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
`else
  assign o_error = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      index        <= '0;
      delay_cnt    <= '0;
      o_sccb_start <= 1'b0;
      o_sccb_word  <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
`ifdef SCCB_INIT_TIMEOUT_EN
      tmo_cnt      <= '0;
      o_error      <= 1'b0;
`endif
    end else begin
      o_sccb_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            state  <= S_FETCH;
            o_busy <= 1'b1;
          end
        end
        S_FETCH: begin
          // Last ROM slot acts as an implicit end so the index never wraps.
          if (rom_entry == END_MARK || index == LAST_IDX) begin
            state  <= S_FINISHED;
            o_busy <= 1'b0;
            o_done <= 1'b1;
          end else if (rom_entry == DELAY_MARK) begin
            state     <= S_DELAY;
            delay_cnt <= DCW'(DELAY_CYCLES - 1);
          end else begin
            state        <= S_ISSUE;
            o_sccb_word  <= {DEV_ID, rom_entry};
            o_sccb_start <= 1'b1;
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
`ifdef SCCB_INIT_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
        end
        S_WAIT: begin
          if (i_sccb_done) begin
            index <= index + 1'b1;
            state <= S_FETCH;
          end
`ifdef SCCB_INIT_TIMEOUT_EN
          else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state   <= S_ERROR;
            o_busy  <= 1'b0;
            o_error <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        S_DELAY: begin
          if (delay_cnt == '0) begin
            index <= index + 1'b1;
            state <= S_FETCH;
          end else begin
            delay_cnt <= delay_cnt - 1'b1;
          end
        end
        S_FINISHED: state <= S_FINISHED;
        S_ERROR:    state <= S_ERROR;
        default:    state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_init_sequencer.sv
// Self-checking bench for sccb_init_sequencer: fixed vector table, directed corner cases,
// and randomized runs against a ROM-walking reference model.
module tb_sccb_init_sequencer;

  localparam int DLY = 50;
  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_start;
  logic        i_sccb_done;
  logic        o_sccb_start;
  logic [23:0] o_sccb_word;
  logic        o_busy;
  logic        o_done;
  logic        o_error;
  logic [3:0]  o_index;

  sccb_init_sequencer #(
    .DEV_ID        (8'h42),
    .DELAY_CYCLES  (DLY),
    .ROM_DEPTH     (16),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_start     (i_start),
    .i_sccb_done (i_sccb_done),
    .o_sccb_start(o_sccb_start),
    .o_sccb_word (o_sccb_word),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_error     (o_error),
    .o_index     (o_index)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int nstarts = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (o_sccb_start === 1'b1) nstarts <= nstarts + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Gap is measured in clocks from the cycle a stimulus (i_start / i_sccb_done) was driven
  // to the cycle the start pulse is visible.
  typedef struct {
    int          lat;
    bit          spur;
    logic [23:0] word;
    int          gap;
  } vec_t;

  vec_t tbl[6];

  logic [15:0] rom_m[16];
  logic [23:0] exp_w_q[$];
  int          exp_g_q[$];
  int          exp_m_q[$];

  task automatic build_model();
    int pending;
    int mk;
    pending = 0;
    mk = -1;
    exp_w_q.delete();
    exp_g_q.delete();
    exp_m_q.delete();
    for (int i = 0; i < 16; i++) begin
      if (i == 15 || rom_m[i] == 16'hFFFF) break;
      if (rom_m[i] == 16'hFFF0) begin
        pending += DLY + 1;
        mk = i;
      end else begin
        exp_w_q.push_back({8'h42, rom_m[i]});
        exp_g_q.push_back(2 + pending);
        exp_m_q.push_back(mk);
        pending = 0;
        mk = -1;
      end
    end
  endtask

  task automatic wait_start(output int t, output bit ok);
    ok = 1'b0;
    t = cyc;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (o_sccb_start === 1'b1) begin
        ok = 1'b1;
        t = cyc;
        return;
      end
    end
  endtask

  task automatic do_txn(input string nm, input int lat, input bit spur, input int spur_idx,
                        input logic [23:0] exp_w, input int exp_gap, input int t_ref,
                        output int t_done);
    int t;
    bit ok;
    if (spur) begin
      repeat (10) @(negedge clk);
      i_sccb_done = 1'b1;
      @(negedge clk);
      i_sccb_done = 1'b0;
      @(negedge clk);
      chk({nm, " spur_idx"}, 32'(o_index), 32'(spur_idx));
    end
    wait_start(t, ok);
    chk({nm, " start_seen"}, 32'(ok), 32'd1);
    chk({nm, " word"}, 32'(o_sccb_word), 32'(exp_w));
    chk({nm, " gap"}, 32'(t - t_ref), 32'(exp_gap));
    @(negedge clk);
    chk({nm, " pulse_width"}, 32'(o_sccb_start), 32'd0);
    repeat (lat - 1) @(negedge clk);
    i_sccb_done = 1'b1;
    t_done = cyc;
    @(negedge clk);
    i_sccb_done = 1'b0;
  endtask

  task automatic kick(output int t_ref);
    i_start = 1'b1;
    t_ref = cyc;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int t_a, t_b, t, base;
    bit ok;

    rom_m = '{16'h1280, 16'hFFF0, 16'h1204, 16'h40D0, 16'h1101, 16'h0C00, 16'h3E00, 16'hFFFF,
              16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    tbl[0] = '{lat: 20, spur: 1'b0, word: 24'h421280, gap: 2};
    tbl[1] = '{lat: 20, spur: 1'b1, word: 24'h421204, gap: DLY + 3};
    tbl[2] = '{lat: 20, spur: 1'b0, word: 24'h4240D0, gap: 2};
    tbl[3] = '{lat: 20, spur: 1'b0, word: 24'h421101, gap: 2};
    tbl[4] = '{lat: 20, spur: 1'b0, word: 24'h420C00, gap: 2};
    tbl[5] = '{lat: 20, spur: 1'b0, word: 24'h423E00, gap: 2};

    reset = 1'b1;
    i_start = 1'b0;
    i_sccb_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst start", 32'(o_sccb_start), 32'd0);
    chk("rst word", 32'(o_sccb_word), 32'd0);
    chk("rst busy", 32'(o_busy), 32'd0);
    chk("rst done", 32'(o_done), 32'd0);
    chk("rst error", 32'(o_error), 32'd0);
    chk("rst index", 32'(o_index), 32'd0);
    reset = 1'b0;

    // Spurious done in IDLE must not move anything.
    @(negedge clk);
    i_sccb_done = 1'b1;
    @(negedge clk);
    i_sccb_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_spur index", 32'(o_index), 32'd0);
    chk("idle_spur starts", 32'(nstarts), 32'd0);
    chk("idle_spur busy", 32'(o_busy), 32'd0);

    base = nstarts;
    kick(t_a);
    chk("busy after start", 32'(o_busy), 32'd1);
    foreach (tbl[i]) begin
      do_txn($sformatf("tbl%0d", i), tbl[i].lat, tbl[i].spur, 1, tbl[i].word, tbl[i].gap, t_a, t_b);
      t_a = t_b;
    end
    repeat (5) @(negedge clk);
    chk("tbl done", 32'(o_done), 32'd1);
    chk("tbl busy", 32'(o_busy), 32'd0);
    chk("tbl start_count", 32'(nstarts - base), 32'd6);

    base = nstarts;
    i_start = 1'b1;
    repeat (1000) @(negedge clk);
    i_start = 1'b0;
    chk("rerun starts", 32'(nstarts - base), 32'd0);
    chk("rerun done", 32'(o_done), 32'd1);

    // Reset while waiting on the transceiver at index 3.
    do_reset();
    kick(t_a);
    do_txn("rw0", 5, 1'b0, 0, 24'h421280, 2, t_a, t_b);
    do_txn("rw1", 5, 1'b0, 0, 24'h421204, DLY + 3, t_b, t_a);
    wait_start(t, ok);
    chk("rw2 word", 32'(o_sccb_word), 32'h4240D0);
    repeat (4) @(negedge clk);
    chk("rw2 index", 32'(o_index), 32'd3);
    reset = 1'b1;
    #1;
    chk("rw_rst start", 32'(o_sccb_start), 32'd0);
    chk("rw_rst word", 32'(o_sccb_word), 32'd0);
    chk("rw_rst busy", 32'(o_busy), 32'd0);
    chk("rw_rst index", 32'(o_index), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    kick(t_a);
    wait_start(t, ok);
    chk("rw_restart seen", 32'(ok), 32'd1);
    chk("rw_restart word", 32'(o_sccb_word), 32'h421280);
    chk("rw_restart gap", 32'(t - t_a), 32'd2);

    // Randomized latencies and spurious done pulses, checked against the ROM-walk model.
    build_model();
    for (int r = 0; r < 3; r++) begin
      do_reset();
      base = nstarts;
      kick(t_a);
      foreach (exp_w_q[k]) begin
        do_txn($sformatf("rnd%0d_%0d", r, k), int'($urandom_range(1, 30)),
               (exp_m_q[k] >= 0) && ($urandom_range(0, 1) == 1), exp_m_q[k],
               exp_w_q[k], exp_g_q[k], t_a, t_b);
        t_a = t_b;
      end
      repeat (5) @(negedge clk);
      chk($sformatf("rnd%0d done", r), 32'(o_done), 32'd1);
      chk($sformatf("rnd%0d busy", r), 32'(o_busy), 32'd0);
      chk($sformatf("rnd%0d starts", r), 32'(nstarts - base), 32'(exp_w_q.size()));
    end

`ifdef SCCB_INIT_TIMEOUT_EN
    do_reset();
    kick(t_a);
    wait_start(t, ok);
    chk("tmo start_seen", 32'(ok), 32'd1);
    t_b = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (o_error === 1'b1) begin
        t_b = cyc;
        break;
      end
    end
    chk("tmo latency", 32'(t_b - t), 32'(TMO + 1));
    chk("tmo busy", 32'(o_busy), 32'd0);
    chk("tmo done", 32'(o_done), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
